// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_pkg
// Brief   : Shared definitions for the six-digit seven-segment scan
//           controller: FSM encoding, hex-to-segment table, digit count and
//           the all-dark output constants.
// Revision: 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Commons are active-low, so all ones means no digit is selected.
  localparam logic [5:0] c_com_off = 6'h3F;
  localparam logic [7:0] c_seg_off = 8'h00;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Segment patterns for hex 0..F, bit0 = a .. bit6 = g.
  localparam logic [6:0] c_hex_table [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : seg_if
// Brief   : Register-write and display-drive signals of the scan controller.
//           The master side is the bus/board, the slave side the controller.
// Revision: 1.0 - initial release
// ============================================================================
interface seg_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       enable;
  logic [7:0] seg_data;
  logic [5:0] seg_com;

  modport master (
    output wr_en, wr_addr, wr_data, enable,
    input  seg_data, seg_com
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, enable,
    output seg_data, seg_com
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl_hex_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg_hex_decode
// Brief   : Combinational 4-bit hex to 7-segment (active-high) lookup.
// Revision: 1.0 - initial release
// ============================================================================
module seg_hex_decode (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  import seg_pkg::*;

  assign o_seg = c_hex_table[i_hex];
endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl
// Brief   : Six-digit multiplexed seven-segment scan controller. Digits are
//           written through a small register file and shown one at a time
//           for SCAN_DIV cycles each.
//           Optional macro SEG_GHOST_BLANK_EN inserts BLANK_CYC dark cycles
//           between digits to suppress ghosting.
// Revision: 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 5000,
  parameter int BLANK_CYC = 50
) (
  input  logic  clk,
  input  logic  rst,
  seg_if.slave  bus
);
  import seg_pkg::*;

  if (SCAN_DIV < 2 || SCAN_DIV > 65535 || BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_bad_cfg
    $error("seg_scan_ctrl: SCAN_DIV or BLANK_CYC out of range");
  end

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [15:0] r_presc;
`ifdef SEG_GHOST_BLANK_EN
  logic [7:0]  r_gap;
`endif
  logic [5:0]  r_digit [NUM_DIGITS];
  logic [5:0]  r_seg_com;
  logic [7:0]  r_seg_data;

  logic        w_wr_hit;
  logic [2:0]  w_idx_inc;
  logic [2:0]  w_load_idx;
  logic [5:0]  w_load_digit;
  logic [6:0]  w_load_seg;
  logic [5:0]  w_load_com;
  logic [7:0]  w_load_data;
  logic [1:0]  w_unused_wr_data;

  assign w_unused_wr_data = bus.wr_data[7:6];
  assign w_wr_hit         = bus.wr_en && (bus.wr_addr < 3'(NUM_DIGITS));

  // The digit about to be loaded: digit 0 when leaving OFF, otherwise the
  // next digit in rotation. Read before any same-edge write lands.
  assign w_idx_inc    = (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
  assign w_load_idx   = (r_state == ST_OFF) ? 3'd0 : w_idx_inc;
  assign w_load_digit = r_digit[w_load_idx];

  seg_hex_decode u_hex_decode (
    .i_hex (w_load_digit[3:0]),
    .o_seg (w_load_seg)
  );

  // A disabled digit keeps the whole slot dark.
  assign w_load_com  = w_load_digit[5] ? ~(6'd1 << w_load_idx) : c_com_off;
  assign w_load_data = w_load_digit[5] ? {w_load_digit[4], w_load_seg} : c_seg_off;

  // Digit register file, writable in every scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digit[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_digit[bus.wr_addr] <= bus.wr_data[5:0];
    end
  end

  // Scan FSM; outputs are loaded together with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_idx      <= '0;
      r_presc    <= '0;
`ifdef SEG_GHOST_BLANK_EN
      r_gap      <= '0;
`endif
      r_seg_com  <= c_com_off;
      r_seg_data <= c_seg_off;
    end else if (!bus.enable) begin
      r_state    <= ST_OFF;
      r_idx      <= '0;
      r_presc    <= '0;
`ifdef SEG_GHOST_BLANK_EN
      r_gap      <= '0;
`endif
      r_seg_com  <= c_com_off;
      r_seg_data <= c_seg_off;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_state    <= ST_SHOW;
          r_idx      <= w_load_idx;
          r_presc    <= '0;
          r_seg_com  <= w_load_com;
          r_seg_data <= w_load_data;
        end
        ST_SHOW: begin
          if (r_presc == 16'(SCAN_DIV - 1)) begin
            r_presc    <= '0;
`ifdef SEG_GHOST_BLANK_EN
            r_state    <= ST_GAP;
            r_gap      <= '0;
            r_seg_com  <= c_com_off;
            r_seg_data <= c_seg_off;
`else
            r_idx      <= w_load_idx;
            r_seg_com  <= w_load_com;
            r_seg_data <= w_load_data;
`endif
          end else begin
            r_presc <= r_presc + 16'd1;
          end
        end
`ifdef SEG_GHOST_BLANK_EN
        ST_GAP: begin
          if (r_gap == 8'(BLANK_CYC - 1)) begin
            r_state    <= ST_SHOW;
            r_gap      <= '0;
            r_idx      <= w_load_idx;
            r_presc    <= '0;
            r_seg_com  <= w_load_com;
            r_seg_data <= w_load_data;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
`endif
        default: begin
          r_state    <= ST_OFF;
          r_idx      <= '0;
          r_presc    <= '0;
          r_seg_com  <= c_com_off;
          r_seg_data <= c_seg_off;
        end
      endcase
    end
  end

  assign bus.seg_com  = r_seg_com;
  assign bus.seg_data = r_seg_data;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_scan_ctrl
// Brief   : Directed self-checking bench for seg_scan_ctrl with SCAN_DIV=4,
//           BLANK_CYC=2. Follows SEG_GHOST_BLANK_EN for the slot length.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int SD   = 4;
`ifdef SEG_GHOST_BLANK_EN
  localparam int GAP  = 2;
`else
  localparam int GAP  = 0;
`endif
  localparam int SLOT = SD + GAP;
  localparam int PER  = 6 * SLOT;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  logic [5:0]  m_dig [6];
  logic [5:0]  cur;
  logic [13:0] exp_v;

  seg_if bus ();

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {seg_com, seg_data} for output cycle k of a scan started from
  // OFF, given the value sampled at the start of the current slot.
  function automatic logic [13:0] exp_out(input int k, input logic [5:0] c);
    int pos;
    int slot;
    pos  = k % SLOT;
    slot = (k / SLOT) % 6;
    if (pos >= SD || !c[5]) return {6'h3F, 8'h00};
    return {~(6'd1 << slot), c[4], SEG_TAB[c[3:0]]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    if (a < 3'd6) m_dig[a] = d[5:0];
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({bus.seg_com, bus.seg_data} !== 14'h3F00) begin
      errors++;
      $display("FAIL reset_state: got com=%h data=%h, expected com=3f data=00", bus.seg_com, bus.seg_data);
    end
    bus.enable = 1'b1;
    tick();
    vectors++;
    if ({bus.seg_com, bus.seg_data} !== 14'h3F00) begin
      errors++;
      $display("FAIL reset_held_enabled: got com=%h data=%h, expected com=3f data=00", bus.seg_com, bus.seg_data);
    end
    rst = 1'b0;
    for (int k = 0; k < PER + SLOT; k++) begin
      tick();
      if (k % SLOT == 0) cur = m_dig[(k / SLOT) % 6];
      exp_v = exp_out(k, cur);
      vectors++;
      if ({bus.seg_com, bus.seg_data} !== exp_v) begin
        errors++;
        $display("FAIL no_writes_dark k=%0d: got com=%h data=%h, expected com=%h data=%h", k, bus.seg_com, bus.seg_data, exp_v[13:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_digit0();
    bus.enable = 1'b0;
    tick();
    vectors++;
    if ({bus.seg_com, bus.seg_data} !== 14'h3F00) begin
      errors++;
      $display("FAIL off_dark: got com=%h data=%h, expected com=3f data=00", bus.seg_com, bus.seg_data);
    end
    wr(3'd0, 8'h21);
    bus.enable = 1'b1;
    for (int k = 0; k < 2 * PER; k++) begin
      tick();
      if (k % SLOT == 0) cur = m_dig[(k / SLOT) % 6];
      exp_v = exp_out(k, cur);
      vectors++;
      if ({bus.seg_com, bus.seg_data} !== exp_v) begin
        errors++;
        $display("FAIL digit0_scan k=%0d: got com=%h data=%h, expected com=%h data=%h", k, bus.seg_com, bus.seg_data, exp_v[13:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_wrap();
    bus.enable = 1'b0;
    tick();
    wr(3'd5, 8'h38);
    bus.enable = 1'b1;
    for (int k = 0; k < PER + SLOT + SD; k++) begin
      tick();
      if (k % SLOT == 0) cur = m_dig[(k / SLOT) % 6];
      exp_v = exp_out(k, cur);
      vectors++;
      if ({bus.seg_com, bus.seg_data} !== exp_v) begin
        errors++;
        $display("FAIL digit5_wrap k=%0d: got com=%h data=%h, expected com=%h data=%h", k, bus.seg_com, bus.seg_data, exp_v[13:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_disable();
    bus.enable = 1'b0;
    tick();
    wr(3'd3, 8'h2A);
    bus.enable = 1'b1;
    for (int k = 0; k < 3 * SLOT + 2; k++) begin
      tick();
      if (k % SLOT == 0) cur = m_dig[(k / SLOT) % 6];
      exp_v = exp_out(k, cur);
      vectors++;
      if ({bus.seg_com, bus.seg_data} !== exp_v) begin
        errors++;
        $display("FAIL pre_disable k=%0d: got com=%h data=%h, expected com=%h data=%h", k, bus.seg_com, bus.seg_data, exp_v[13:8], exp_v[7:0]);
      end
    end
    bus.enable = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      vectors++;
      if ({bus.seg_com, bus.seg_data} !== 14'h3F00) begin
        errors++;
        $display("FAIL disable_dark j=%0d: got com=%h data=%h, expected com=3f data=00", j, bus.seg_com, bus.seg_data);
      end
    end
    bus.enable = 1'b1;
    for (int k = 0; k < PER; k++) begin
      tick();
      if (k % SLOT == 0) cur = m_dig[(k / SLOT) % 6];
      exp_v = exp_out(k, cur);
      vectors++;
      if ({bus.seg_com, bus.seg_data} !== exp_v) begin
        errors++;
        $display("FAIL reenable_restart k=%0d: got com=%h data=%h, expected com=%h data=%h", k, bus.seg_com, bus.seg_data, exp_v[13:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_reset_gap();
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    for (int k = 0; k <= SD; k++) begin
      tick();
      if (k % SLOT == 0) cur = m_dig[(k / SLOT) % 6];
      exp_v = exp_out(k, cur);
      vectors++;
      if ({bus.seg_com, bus.seg_data} !== exp_v) begin
        errors++;
        $display("FAIL pre_reset k=%0d: got com=%h data=%h, expected com=%h data=%h", k, bus.seg_com, bus.seg_data, exp_v[13:8], exp_v[7:0]);
      end
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.seg_com, bus.seg_data} !== 14'h3F00) begin
      errors++;
      $display("FAIL async_reset_dark: got com=%h data=%h, expected com=3f data=00", bus.seg_com, bus.seg_data);
    end
    for (int i = 0; i < 6; i++) m_dig[i] = 6'h00;
    tick();
    rst = 1'b0;
    bus.enable = 1'b0;
    tick();
    wr(3'd1, 8'h23);
    bus.enable = 1'b1;
    for (int k = 0; k < PER + SLOT; k++) begin
      tick();
      if (k % SLOT == 0) cur = m_dig[(k / SLOT) % 6];
      exp_v = exp_out(k, cur);
      vectors++;
      if ({bus.seg_com, bus.seg_data} !== exp_v) begin
        errors++;
        $display("FAIL post_reset_cleared k=%0d: got com=%h data=%h, expected com=%h data=%h", k, bus.seg_com, bus.seg_data, exp_v[13:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_ignored_and_live_write();
    bus.enable = 1'b0;
    tick();
    wr(3'd6, 8'h2F);
    wr(3'd7, 8'h2F);
    wr(3'd2, 8'h24);
    wr(3'd3, 8'h27);
    bus.enable = 1'b1;
    for (int k = 0; k < 2 * PER; k++) begin
      if (k == 2 * SLOT + 1) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'h29;
      end else if (k == 3 * SLOT) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'h2E;
      end
      tick();
      bus.wr_en = 1'b0;
      if (k % SLOT == 0) cur = m_dig[(k / SLOT) % 6];
      if (k == 2 * SLOT + 1) m_dig[2] = 6'h29;
      if (k == 3 * SLOT) m_dig[3] = 6'h2E;
      exp_v = exp_out(k, cur);
      vectors++;
      if ({bus.seg_com, bus.seg_data} !== exp_v) begin
        errors++;
        $display("FAIL ignored_live_write k=%0d: got com=%h data=%h, expected com=%h data=%h", k, bus.seg_com, bus.seg_data, exp_v[13:8], exp_v[7:0]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_data = 8'h00;
    cur         = 6'h00;
    for (int i = 0; i < 6; i++) m_dig[i] = 6'h00;

    test_reset();
    test_digit0();
    test_wrap();
    test_disable();
    test_reset_gap();
    test_ignored_and_live_write();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 5000: CLK cycles each digit is displayed (range 2..65535).
REQ-002 Parameter BLANK_CYC, default 50: CLK cycles of inter-digit blanking (range 1..255); used only when SEG_GHOST_BLANK_EN is defined.
REQ-003 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 WR_EN  in  1  single-cycle write strobe from the bus address decoder.
REQ-006 WR_ADDR  in  3  digit index 0..5; values 6 and 7 are ignored.
REQ-007 WR_DATA  in  8  [3:0] hex value, [4] decimal point, [5] digit enable, [7:6] ignored.
REQ-008 ENABLE  in  1  scan enable; low forces the display dark.
REQ-009 SEG_DATA  out  8  registered segment drive, active-high: bit0=a .. bit6=g, bit7=dp.
REQ-010 SEG_COM  out  6  registered digit commons, active-low one-hot; bit i selects digit i.

Function
REQ-011 Six 6-bit digit registers (hex, dp, en) are written on the CLK edge where WR_EN=1 and WR_ADDR<6; a write takes effect in the cycle after the strobe.
REQ-012 FSM states are OFF, SHOW and GAP.
REQ-013 OFF: SEG_COM=6'h3F, SEG_DATA=8'h00, digit index=0, prescaler=0; leaves to SHOW on the first cycle ENABLE=1.
REQ-014 SHOW: SEG_COM drives bit[idx] low and SEG_DATA drives {dp, seg(hex)} of digit idx. If the en bit of digit idx is 0, SEG_COM=6'h3F and SEG_DATA=8'h00 for the whole slot.
REQ-015 The digit's value is sampled on entry to SHOW and held for the whole slot; a write to the active digit appears at its next slot.
REQ-016 The prescaler counts 0..SCAN_DIV-1 in SHOW. At terminal count the FSM goes to GAP (blank build) or directly to SHOW of idx+1 (no-blank build).
REQ-017 GAP: SEG_COM=6'h3F, SEG_DATA=8'h00 for exactly BLANK_CYC cycles, then SHOW with idx advanced.
REQ-018 The digit index wraps from 5 to 0.
REQ-019 ENABLE=0 in any state moves the FSM to OFF on the next edge; the outputs go dark in that same registered cycle.
REQ-020 WR_EN and ENABLE are independent; writes are accepted in every state, including OFF.
REQ-021 Hex decode for 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-022 A write and a slot transition in the same cycle: the write lands in the register, and the slot samples the pre-write value.

Reset
REQ-023 RESET=1 immediately forces FSM=OFF, idx=0, prescaler=0, gap counter=0, SEG_COM=6'h3F, SEG_DATA=8'h00, and clears all digit registers to 0 (digits disabled).
REQ-024 RESET asserted mid-slot or mid-gap aborts the slot. After release, scanning restarts at digit 0 if ENABLE=1.

Configuration
REQ-025 Macro SEG_GHOST_BLANK_EN defined: the GAP state and gap counter exist, giving a digit period of SCAN_DIV+BLANK_CYC cycles.
REQ-026 Macro SEG_GHOST_BLANK_EN undefined: GAP is not built, BLANK_CYC is ignored, and the digit period is SCAN_DIV cycles.

Structure
REQ-027 Package seg_pkg holds the FSM state encoding, the 16-entry hex-to-segment constant table, NUM_DIGITS=6 and the all-off constants.
REQ-028 Sub-module seg_hex_decode is a combinational 4-bit-to-7-segment lookup using the seg_pkg table.

Verification
All scenarios use SCAN_DIV=4 and BLANK_CYC=2.
REQ-029 Reset release with ENABLE=1 and no writes -> SEG_COM=3F and SEG_DATA=00 in every cycle.
REQ-030 Write digit0=0x21 (hex 1, en), ENABLE=1 -> SEG_COM=3E, SEG_DATA=06 for 4 cycles, then 2 dark cycles (blank build), then digits 1..5 dark; 36-cycle period.
REQ-031 Write digit5=0x38 (hex 8, dp, en) -> slot 5 shows SEG_COM=1F, SEG_DATA=FF; next slot is digit 0 (wrap).
REQ-032 Drop ENABLE mid-SHOW of digit 3 -> next cycle SEG_COM=3F; on re-enable, scan restarts at digit 0.
REQ-033 Pulse RESET mid-GAP -> outputs dark that cycle, all digit registers read back disabled, and the scan resumes at digit 0.
REQ-034 Write WR_ADDR=6 with data 0x2F -> no digit register changes and the display is unchanged; write digit 2 during its own slot -> the old value holds until its next slot.
